// File: rtl/tpu_drain_pkg.sv
// Shared types and constants for the TPU result drain: FSM states,
// frame geometry and the byte-index type used by the serializer.
package tpu_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_SEND
  } state_t;

  // Header + 8 result bytes + checksum
  localparam int FRAME_LEN = 10;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  typedef logic [3:0] byte_idx_t;

endpackage

// File: rtl/tpu_frame_serializer.sv
// Holds the captured PE words and streams them out as a 10-byte frame
// (header, big-endian words PE30..PE33, XOR checksum) over valid/ready.
module tpu_frame_serializer
  import tpu_drain_pkg::*;
#(
  parameter int         NUM_PE      = 4,
  parameter int         NORM_W      = 16,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NUM_PE*NORM_W-1:0] pe_words,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic                     frame_last_accepted
);

  logic [NORM_W-1:0] words_q [NUM_PE];
  logic [7:0]        csum_q;
  logic [7:0]        csum_next;
  byte_idx_t         idx_q;
  logic              valid_q;
  logic [2:0]        rel;
  logic [NORM_W-1:0] sel_word;
  logic [7:0]        byte_mux;

  // Checksum of the incoming words, so it is fixed at capture time
  always_comb begin
    // NOTE: every variable written here gets a value before any branch or loop, so no latch can be inferred.
    csum_next = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      csum_next ^= pe_words[i*NORM_W +: 8] ^ pe_words[i*NORM_W+8 +: 8];
    end
  end

  // Select the byte for the current index: header, word hi/lo, checksum
  always_comb begin
    rel      = 3'(idx_q - byte_idx_t'(1));
    sel_word = words_q[rel[2:1]];
    byte_mux = '0;
    if (idx_q == byte_idx_t'(0)) begin
      byte_mux = HEADER_BYTE;
    end else if (idx_q == byte_idx_t'(FRAME_LEN - 1)) begin
      byte_mux = csum_q;
    end else begin
      byte_mux = rel[0] ? sel_word[7:0] : sel_word[15:8];
    end
  end

  assign out_data            = valid_q ? byte_mux : 8'h00;
  assign out_valid           = valid_q;
  assign frame_last_accepted = valid_q & out_ready & (idx_q == byte_idx_t'(FRAME_LEN - 1));

  // Capture on load, then advance one byte per accepted transfer
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
    if (reset) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      csum_q  <= '0;
      // NOTE: the word storage is cleared on reset too, so nothing captured before a reset can reappear afterwards.
      for (int i = 0; i < NUM_PE; i++) begin
        words_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NUM_PE; i++) begin
        words_q[i] <= pe_words[i*NORM_W +: NORM_W];
      end
      csum_q  <= csum_next;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      if (idx_q == byte_idx_t'(FRAME_LEN - 1)) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + byte_idx_t'(1);
      end
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Host-side job controller: pulses tpu_start, waits for a rising tpu_done
// (with timeout), captures the bottom-row PE results and hands them to the
// frame serializer. Counts completed frames.
module tpu_result_drain
  import tpu_drain_pkg::*;
#(
  parameter int         NUM_PE         = 4,
  parameter int         NORM_W         = 16,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] HEADER_BYTE    = HEADER_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  output logic                     tpu_start,
  input  logic                     tpu_done,
  input  logic [NUM_PE*NORM_W-1:0] pe_norm_in,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              frames_sent
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t           state_q;
  state_t           state_d;
  logic             done_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [15:0]      frames_q;
  logic             capture;
  logic             tmo_hit;
  logic             load;
  logic             last_acc;

  // Only a fresh rising edge of done counts; a level left high is ignored
  assign capture = tpu_done & ~done_q;
  assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and control outputs
  always_comb begin
    state_d     = state_q;
    tpu_start   = 1'b0;
    timeout_err = 1'b0;
    load        = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_START;
      end
      ST_START: begin
        tpu_start = 1'b1;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (capture) begin
          load    = 1'b1;
          state_d = ST_SEND;
        end else if (tmo_hit) begin
          timeout_err = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (last_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, done history, timeout counter and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      tmo_cnt_q <= '0;
      frames_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= tpu_done;
      if (state_q == ST_START) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_WAIT_DONE && !capture && !tmo_hit) begin
        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
      if (last_acc) begin
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  assign frames_sent = frames_q;

  tpu_frame_serializer #(
    .NUM_PE      (NUM_PE),
    .NORM_W      (NORM_W),
    .HEADER_BYTE (HEADER_BYTE)
  ) u_serializer (
    .clk                 (clk),
    .reset               (reset),
    .load                (load),
    .pe_words            (pe_norm_in),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .frame_last_accepted (last_acc)
  );

endmodule

// File: tb/tb_tpu_result_drain.sv
// Directed bench for tpu_result_drain with a byte scoreboard: expected frame
// bytes are queued when done is raised and popped as the DUT transfers them.
module tb_tpu_result_drain;

  localparam int NUM_PE         = 4;
  localparam int NORM_W         = 16;
  localparam int TIMEOUT_CYCLES = 4096;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     go;
  logic                     tpu_start;
  logic                     tpu_done;
  logic [NUM_PE*NORM_W-1:0] pe_norm_in;
  logic [7:0]               out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     timeout_err;
  logic [15:0]              frames_sent;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [15:0] fs_exp;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  tpu_result_drain #(
    .NUM_PE         (NUM_PE),
    .NORM_W         (NORM_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .HEADER_BYTE    (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .tpu_start   (tpu_start),
    .tpu_done    (tpu_done),
    .pe_norm_in  (pe_norm_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference frame: header, each word hi then lo (PE30 first), XOR of the 8 data bytes
  function automatic void push_frame(input logic [63:0] d);
    logic [7:0]  cs;
    logic [15:0] w;
    cs = 8'h00;
    sb.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      w = d[16*i +: 16];
      sb.push_back(w[15:8]);
      sb.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    sb.push_back(cs);
  endfunction

  // Byte monitor: scoreboard compare on transfer, hold check after a stall
  always @(negedge clk) begin
    if (prev_stall) begin
      check("stall_valid_hold", 32'(out_valid), 32'd1);
      check("stall_data_hold", 32'(out_data), 32'(prev_data));
    end
    if (!reset && out_valid && out_ready) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("frame_byte", 32'(out_data), 32'(sb.pop_front()));
    end
    prev_stall = !reset && out_valid && !out_ready;
    prev_data  = out_data;
  end

  // One complete job: go, done 30 cycles after tpu_start, then drain the frame
  task automatic run_job(input logic [63:0] data, input bit bp, input bit go_hold);
    int starts, vcyc, acc;
    bit done_flag;
    go = 1'b1;
    cycle();
    if (!go_hold) go = 1'b0;
    check("start_pulse", 32'(tpu_start), 32'd1);
    check("busy_in_start", 32'(busy), 32'd1);
    starts = 0;
    repeat (30) begin
      cycle();
      if (tpu_start) starts++;
    end
    pe_norm_in = data;
    tpu_done   = 1'b1;
    push_frame(data);
    vcyc      = 0;
    acc       = 0;
    done_flag = 1'b0;
    for (int k = 0; k < 200; k++) begin
      out_ready = (!bp || k == 0) ? 1'b1 : (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
      if (out_valid) vcyc++;
      if (out_valid && out_ready) acc++;
      cycle();
      if (tpu_start) starts++;
      if (k == 0) check("valid_after_capture", 32'(out_valid), 32'd1);
      if (!busy) begin
        done_flag = 1'b1;
        break;
      end
    end
    go        = 1'b0;
    tpu_done  = 1'b0;
    out_ready = 1'b1;
    check("frame_completed", 32'(done_flag), 32'd1);
    check("bytes_per_frame", acc, 10);
    if (!bp) check("full_rate_cycles", vcyc, 10);
    check("no_extra_start", starts, 0);
    fs_exp = fs_exp + 16'd1;
    check("frames_sent", 32'(frames_sent), 32'(fs_exp));
    check("valid_low_after_frame", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, vcnt, acc, k;
    bit found;
    reset      = 1'b1;
    go         = 1'b0;
    tpu_done   = 1'b0;
    pe_norm_in = '0;
    out_ready  = 1'b1;
    fs_exp     = 16'h0000;
    repeat (3) cycle();
    check("rst_tpu_start", 32'(tpu_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_frames_sent", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    cycle();

    // Basic frame at full rate
    run_job({16'h8000, 16'hABCD, 16'h00FF, 16'h1234}, 1'b0, 1'b0);

    // Same data under 1,0,0,1 backpressure
    run_job({16'h8000, 16'hABCD, 16'h00FF, 16'h1234}, 1'b1, 1'b0);

    // Stale done: level high before go, never toggled
    tpu_done = 1'b1;
    repeat (3) cycle();
    go = 1'b1;
    cycle();
    go = 1'b0;
    check("stale_start_pulse", 32'(tpu_start), 32'd1);
    n     = 0;
    vcnt  = 0;
    found = 1'b0;
    for (int i = 1; i <= 5000; i++) begin
      cycle();
      if (out_valid) vcnt++;
      if (timeout_err) begin
        n     = i;
        found = 1'b1;
        break;
      end
    end
    check("timeout_seen", 32'(found), 32'd1);
    check("timeout_delay", n, TIMEOUT_CYCLES);
    check("stale_no_valid", vcnt, 0);
    cycle();
    check("timeout_one_cycle", 32'(timeout_err), 32'd0);
    check("idle_after_timeout", 32'(busy), 32'd0);
    check("frames_after_timeout", 32'(frames_sent), 32'(fs_exp));
    tpu_done = 1'b0;
    cycle();

    // go held high through WAIT_DONE and SEND
    run_job({16'hFEDC, 16'h0001, 16'h7F80, 16'h5A3C}, 1'b0, 1'b1);

    // Reset after byte 4 transfers
    go = 1'b1;
    cycle();
    go = 1'b0;
    repeat (30) cycle();
    pe_norm_in = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tpu_done   = 1'b1;
    push_frame(pe_norm_in);
    acc = 0;
    k   = 0;
    while (acc < 5 && k < 50) begin
      if (out_valid && out_ready) acc++;
      cycle();
      k++;
    end
    check("bytes_before_reset", acc, 5);
    reset     = 1'b1;
    out_ready = 1'b0;
    sb.delete();
    cycle();
    check("midrst_tpu_start", 32'(tpu_start), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_timeout_err", 32'(timeout_err), 32'd0);
    check("midrst_frames_sent", 32'(frames_sent), 32'd0);
    fs_exp    = 16'h0000;
    reset     = 1'b0;
    tpu_done  = 1'b0;
    out_ready = 1'b1;
    cycle();
    run_job({16'h0F0F, 16'hF0F0, 16'hC3C3, 16'h9999}, 1'b0, 1'b0);

    // Frame counter wrap from 0xFFFF
    force dut.frames_q = 16'hFFFF;
    cycle();
    release dut.frames_q;
    cycle();
    check("frames_preload", 32'(frames_sent), 32'h0000_FFFF);
    fs_exp = 16'hFFFF;
    run_job({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, 1'b0, 1'b0);

    repeat (3) cycle();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
